// File: rtl/bus_snoop_requester.sv
// bus_snoop_requester: shared-bus master issuing one op, sampling snoop, capturing HITM line.
module bus_snoop_requester #(
  parameter int lineSize   = 512,
  parameter int addrWidth  = 32,
  parameter int SNOOP_WAIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [7:0]           req_op,
  input  logic [addrWidth-1:0] req_addr,
  output logic [7:0]           sharedOperationOut,
  output logic [lineSize-1:0]  sharedBusOut,
  output logic                 sharedBusOE,
  input  logic [lineSize-1:0]  sharedBusIn,
  input  logic [1:0]           snoopIn,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_snoop,
  output logic [lineSize-1:0]  rsp_data,
  output logic                 rsp_err
);
  localparam int CW = $clog2(SNOOP_WAIT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           op_q, op_d, sh_op_q, sh_op_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic [lineSize-1:0]  sh_bus_q, sh_bus_d, rsp_data_q, rsp_data_d;
  logic                 sh_oe_q, sh_oe_d, req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [1:0]           rsp_snoop_q, rsp_snoop_d;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    sh_op_d     = sh_op_q;
    sh_bus_d    = sh_bus_q;
    sh_oe_d     = sh_oe_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_snoop_d = rsp_snoop_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d     = ISSUE;
        op_d        = req_op;
        addr_d      = req_addr;
        cnt_d       = '0;
        req_ready_d = 1'b0;
        rsp_data_d  = '0;
        rsp_snoop_d = 2'b00;
        rsp_err_d   = 1'b0;
      end
      // First ISSUE cycle arms the bus (or rejects an illegal opcode); the
      // counter then runs while the bus is driven.
      ISSUE: if (!sh_oe_q) begin
        if (op_q == 8'h00) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          sh_oe_d  = 1'b1;
          sh_op_d  = op_q;
          sh_bus_d = lineSize'(addr_q);
        end
      end else if (cnt_q == CW'(SNOOP_WAIT - 1)) begin
        sh_oe_d     = 1'b0;
        sh_op_d     = 8'h00;
        sh_bus_d    = '0;
        state_d     = (snoopIn == 2'b10) ? CAPTURE : RESP;
        rsp_valid_d = snoopIn != 2'b10;
        rsp_snoop_d = (snoopIn == 2'b11) ? 2'b00 : snoopIn;
        rsp_err_d   = snoopIn == 2'b11;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      CAPTURE: begin
        rsp_data_d  = sharedBusIn;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      sh_op_q     <= '0;
      sh_bus_q    <= '0;
      sh_oe_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_snoop_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      sh_op_q     <= sh_op_d;
      sh_bus_q    <= sh_bus_d;
      sh_oe_q     <= sh_oe_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_snoop_q <= rsp_snoop_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
  assign req_ready          = req_ready_q;
  assign sharedOperationOut = sh_op_q;
  assign sharedBusOut       = sh_bus_q;
  assign sharedBusOE        = sh_oe_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_snoop          = rsp_snoop_q;
  assign rsp_data           = rsp_data_q;
  assign rsp_err            = rsp_err_q;
endmodule

// File: tb/tb_bus_snoop_requester.sv
// tb_bus_snoop_requester: directed + random ops against a transaction-level snoop model.
module tb_bus_snoop_requester;
  localparam int SW = 2;
  localparam logic [511:0] LINE = 512'hFC9;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, rsp_ready = 1'b0, force_snoop = 1'b0;
  logic [7:0] req_op = '0;
  logic [31:0] req_addr = '0;
  logic [511:0] junk_line = '0;
  logic [1:0] junk_snoop = '0;
  logic prev_hitm = 1'b0;
  logic req_ready, sharedBusOE, rsp_valid, rsp_err;
  logic [7:0] sharedOperationOut;
  logic [511:0] sharedBusOut, sharedBusIn, rsp_data;
  logic [1:0] snoopIn, rsp_snoop;
  int checks = 0, failures = 0;

  bus_snoop_requester #(.lineSize(512), .addrWidth(32), .SNOOP_WAIT(SW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .sharedOperationOut(sharedOperationOut), .sharedBusOut(sharedBusOut),
    .sharedBusOE(sharedBusOE), .sharedBusIn(sharedBusIn), .snoopIn(snoopIn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_snoop(rsp_snoop),
    .rsp_data(rsp_data), .rsp_err(rsp_err));

  always #5 clk = ~clk;

  function automatic logic [1:0] snoop_of(input logic [3:0] a);
    return (a == 4'h2 || a == 4'h8) ? 2'b01 : (a == 4'h4 || a == 4'hC) ? 2'b10 : 2'b00;
  endfunction

  // Other caches answer from the address on the bus; the HITM owner drives its line the cycle after.
  assign snoopIn = force_snoop ? 2'b11 : sharedBusOE ? snoop_of(sharedBusOut[3:0]) : junk_snoop;
  assign sharedBusIn = (prev_hitm && !sharedBusOE) ? LINE : junk_line;
  always @(posedge clk) prev_hitm <= sharedBusOE && snoop_of(sharedBusOut[3:0]) == 2'b10;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    junk_snoop = 2'($urandom);
    for (int i = 0; i < 16; i++) junk_line[i*32 +: 32] = $urandom;
  endtask

  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input int hold, input bit frc);
    logic ee;
    logic [1:0] es;
    logic [511:0] ed;
    int el, eoe, n, oe_n, bus_bad, stab_bad;
    ee  = (op == 8'h00) || frc;
    es  = ee ? 2'b00 : snoop_of(addr[3:0]);
    ed  = (es == 2'b10) ? LINE : '0;
    el  = (op == 8'h00) ? 1 : (es == 2'b10) ? SW + 2 : SW + 1;
    eoe = (op == 8'h00) ? 0 : SW;
    force_snoop = frc;
    req_op = op;
    req_addr = addr;
    req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("req_ready_busy", req_ready, 0);
    n = 0; oe_n = 0; bus_bad = 0;
    while (n < 20) begin
      tick();
      n++;
      if (sharedBusOE) begin
        oe_n++;
        if (sharedOperationOut !== op || sharedBusOut !== {480'b0, addr}) bus_bad++;
      end else if (sharedOperationOut !== 8'h00) bus_bad++;
      if (rsp_valid) break;
    end
    chk("latency", n, el);
    chk("oe_cycles", oe_n, eoe);
    chk("bus_values", bus_bad, 0);
    chk("rsp_snoop", rsp_snoop, es);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_err", rsp_err, ee);
    stab_bad = 0;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (!rsp_valid || rsp_snoop !== es || rsp_data !== ed || rsp_err !== ee ||
          req_ready || sharedBusOE || sharedOperationOut !== 8'h00) stab_bad++;
    end
    chk("rsp_hold_stable", stab_bad, 0);
    force_snoop = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("consumed", {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    int w;
    logic [7:0] bops [3];
    logic [31:0] baddr [3];
    logic [1:0] bs;
    bops = '{8'h01, 8'h04, 8'h02};
    baddr = '{32'h28, 32'h44, 32'h57};
    tick();
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_bus", {sharedBusOE, sharedOperationOut, sharedBusOut}, '0);
    chk("rst_rsp", {rsp_valid, rsp_snoop, rsp_err, rsp_data}, '0);
    rst = 1'b0;
    tick();
    do_op(8'h01, 32'h12, 0, 1'b0);
    do_op(8'h04, 32'h3C, 0, 1'b0);
    do_op(8'h02, 32'h31, 5, 1'b0);
    do_op(8'h00, 32'h14, 1, 1'b0);
    do_op(8'h01, 32'h14, 2, 1'b1);
    // abort in the second cycle the op is on the bus
    req_op = 8'h01; req_addr = 32'h58; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_oe", sharedBusOE, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_bus", {sharedBusOE, sharedOperationOut}, '0);
    chk("abort_rsp", {rsp_valid, req_ready}, 2'b01);
    do_op(8'h01, 32'h12, 0, 1'b0);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_op = bops[i];
      req_addr = baddr[i];
      w = 0;
      while (!req_ready && w < 20) begin tick(); w++; end
      chk("b2b_ready", req_ready, 1);
      tick();
      chk("b2b_accepted", req_ready, 0);
      w = 0;
      while (!rsp_valid && w < 20) begin tick(); w++; end
      bs = snoop_of(baddr[i][3:0]);
      chk("b2b_valid", rsp_valid, 1);
      chk("b2b_snoop", rsp_snoop, bs);
      chk("b2b_data", rsp_data, (bs == 2'b10) ? LINE : '0);
      tick();
      chk("b2b_consumed", {rsp_valid, req_ready}, 2'b01);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    for (int k = 0; k < 24; k++)
      do_op(8'($urandom_range(0, 4)), $urandom, $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
